// File: rtl/hms_clock_core.sv
// Hour:minute:second timekeeping core with a SETUP edit mode, 12/24-hour display
// mapping and a per-field blink mask; all state runs on clk with clock enables.
module hms_clock_core #(
  parameter logic [31:0] TICK_DIV  = 32'd50_000_000,
  parameter logic [31:0] BLINK_DIV = 32'd12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_pulse,
  input  logic       i_pos_pulse,
  input  logic       i_inc_pulse,
  input  logic       i_dec_pulse,
  input  logic       i_h12,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [2:0] o_blink_mask,
  output logic       o_sec_tick,
  output logic       o_day_wrap
);

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  mode_e       mode_r, mode_nx_s;
  logic [1:0]  pos_r, pos_nx_s;
  logic [5:0]  sec_r, sec_nx_s;
  logic [5:0]  min_r, min_nx_s;
  logic [4:0]  hr_r, hr_nx_s;
  logic [31:0] tick_cnt_r, tick_cnt_nx_s;
  logic [31:0] blink_cnt_r, blink_cnt_nx_s;
  logic        blink_ph_r, blink_ph_nx_s;
  logic        sec_tick_r, sec_tick_nx_s;
  logic        day_wrap_r, day_wrap_nx_s;
  logic        edit_up_s;

  // Wrapping single-field step; out-of-range values fold back to a legal value.
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up);
    logic [5:0] r;
    if (up) begin
      r = (v >= maxv) ? 6'd0 : v + 6'd1;
    end else begin
      r = ((v == 6'd0) || (v > maxv)) ? maxv : v - 6'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] onehot_pos(input logic [1:0] p);
    logic [2:0] r;
    case (p)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] hour_12(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h <= 5'd12) begin
      r = h;
    end else begin
      r = h - 5'd12;
    end
    return r;
  endfunction

  // Next-state logic for mode, edit position, time fields, dividers and pulses.
  always_comb begin
    mode_nx_s      = mode_r;
    pos_nx_s       = pos_r;
    sec_nx_s       = sec_r;
    min_nx_s       = min_r;
    hr_nx_s        = hr_r;
    tick_cnt_nx_s  = tick_cnt_r;
    blink_cnt_nx_s = blink_cnt_r;
    blink_ph_nx_s  = blink_ph_r;
    sec_tick_nx_s  = 1'b0;
    day_wrap_nx_s  = 1'b0;
    edit_up_s      = i_inc_pulse;

    case (mode_r)
      MODE_CLOCK: begin
        if (i_mode_pulse) begin
          mode_nx_s      = MODE_SETUP;
          pos_nx_s       = 2'd0;
          blink_ph_nx_s  = 1'b0;
          blink_cnt_nx_s = 32'd0;
          tick_cnt_nx_s  = 32'd0;
        end else if (tick_cnt_r >= (TICK_DIV - 32'd1)) begin
          tick_cnt_nx_s = 32'd0;
          sec_tick_nx_s = 1'b1;
          if (sec_r >= 6'd59) begin
            sec_nx_s = 6'd0;
            if (min_r >= 6'd59) begin
              min_nx_s = 6'd0;
              if (hr_r >= 5'd23) begin
                hr_nx_s       = 5'd0;
                day_wrap_nx_s = 1'b1;
              end else begin
                hr_nx_s = hr_r + 5'd1;
              end
            end else begin
              min_nx_s = min_r + 6'd1;
            end
          end else begin
            sec_nx_s = sec_r + 6'd1;
          end
        end else begin
          tick_cnt_nx_s = tick_cnt_r + 32'd1;
        end
      end

      MODE_SETUP: begin
        tick_cnt_nx_s = 32'd0;
        if (i_mode_pulse) begin
          mode_nx_s      = MODE_CLOCK;
          blink_ph_nx_s  = 1'b0;
          blink_cnt_nx_s = 32'd0;
        end else if (i_pos_pulse) begin
          pos_nx_s       = (pos_r >= 2'd2) ? 2'd0 : pos_r + 2'd1;
          blink_ph_nx_s  = 1'b0;
          blink_cnt_nx_s = 32'd0;
        end else if (i_inc_pulse ^ i_dec_pulse) begin
          blink_ph_nx_s  = 1'b0;
          blink_cnt_nx_s = 32'd0;
          case (pos_r)
            2'd0:    sec_nx_s = wrap_step(sec_r, 6'd59, edit_up_s);
            2'd1:    min_nx_s = wrap_step(min_r, 6'd59, edit_up_s);
            2'd2:    hr_nx_s  = 5'(wrap_step({1'b0, hr_r}, 6'd23, edit_up_s));
            default: pos_nx_s = 2'd0;
          endcase
        end else if (blink_cnt_r >= (BLINK_DIV - 32'd1)) begin
          blink_cnt_nx_s = 32'd0;
          blink_ph_nx_s  = ~blink_ph_r;
        end else begin
          blink_cnt_nx_s = blink_cnt_r + 32'd1;
        end
      end

      default: begin
        mode_nx_s = MODE_CLOCK;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= MODE_CLOCK;
      pos_r       <= 2'd0;
      sec_r       <= 6'd0;
      min_r       <= 6'd0;
      hr_r        <= 5'd0;
      tick_cnt_r  <= 32'd0;
      blink_cnt_r <= 32'd0;
      blink_ph_r  <= 1'b0;
      sec_tick_r  <= 1'b0;
      day_wrap_r  <= 1'b0;
    end else begin
      mode_r      <= mode_nx_s;
      pos_r       <= pos_nx_s;
      sec_r       <= sec_nx_s;
      min_r       <= min_nx_s;
      hr_r        <= hr_nx_s;
      tick_cnt_r  <= tick_cnt_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      blink_ph_r  <= blink_ph_nx_s;
      sec_tick_r  <= sec_tick_nx_s;
      day_wrap_r  <= day_wrap_nx_s;
    end
  end

  // Hour format follows i_h12 combinationally; the stored hour is always 24h.
  assign o_sec        = sec_r;
  assign o_min        = min_r;
  assign o_hour       = i_h12 ? hour_12(hr_r) : hr_r;
  assign o_pm         = i_h12 & (hr_r >= 5'd12);
  assign o_mode       = mode_r;
  assign o_pos        = pos_r;
  assign o_blink_mask = ((mode_r == MODE_SETUP) && blink_ph_r) ? onehot_pos(pos_r) : 3'b000;
  assign o_sec_tick   = sec_tick_r;
  assign o_day_wrap   = day_wrap_r;

endmodule

// File: tb/tb_hms_clock_core.sv
// Directed plus randomized bench for hms_clock_core against a seconds-of-day model.
module tb_hms_clock_core;
  localparam int TD = 4;
  localparam int BD = 3;

  logic       clk, rst_n;
  logic       i_mode_pulse, i_pos_pulse, i_inc_pulse, i_dec_pulse, i_h12;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_pm, o_mode;
  logic [1:0] o_pos;
  logic [2:0] o_blink_mask;
  logic       o_sec_tick, o_day_wrap;

  hms_clock_core #(.TICK_DIV(32'd4), .BLINK_DIV(32'd3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mode_pulse(i_mode_pulse), .i_pos_pulse(i_pos_pulse),
    .i_inc_pulse(i_inc_pulse), .i_dec_pulse(i_dec_pulse), .i_h12(i_h12),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_pm(o_pm),
    .o_mode(o_mode), .o_pos(o_pos), .o_blink_mask(o_blink_mask),
    .o_sec_tick(o_sec_tick), .o_day_wrap(o_day_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: time as seconds of the day, counters as elapsed cycles.
  int tod, md, ps, tcnt, bcnt, bph, mtick, mwrap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tod = 0; md = 0; ps = 0; tcnt = 0; bcnt = 0; bph = 0; mtick = 0; mwrap = 0;
  endtask

  task automatic model_step(input bit mo, input bit po, input bit inc, input bit dec);
    int h, m, s, d;
    mtick = 0;
    mwrap = 0;
    if (md == 0) begin
      if (mo) begin
        md = 1; ps = 0; bph = 0; bcnt = 0; tcnt = 0;
      end else begin
        tcnt++;
        if (tcnt == TD) begin
          tcnt = 0;
          mtick = 1;
          tod = (tod + 1) % 86400;
          if (tod == 0) mwrap = 1;
        end
      end
    end else begin
      if (mo) begin
        md = 0; tcnt = 0; bph = 0; bcnt = 0;
      end else if (po) begin
        ps = (ps + 1) % 3; bph = 0; bcnt = 0;
      end else if (inc != dec) begin
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        d = inc ? 1 : -1;
        if (ps == 0) s = (s + d + 60) % 60;
        else if (ps == 1) m = (m + d + 60) % 60;
        else h = (h + d + 24) % 24;
        tod = h * 3600 + m * 60 + s;
        bph = 0; bcnt = 0;
      end else begin
        bcnt++;
        if (bcnt == BD) begin
          bcnt = 0;
          bph = 1 - bph;
        end
      end
    end
  endtask

  task automatic compare_model();
    int h24, hd;
    h24 = tod / 3600;
    hd = i_h12 ? ((h24 % 12 == 0) ? 12 : h24 % 12) : h24;
    check_eq("m_sec", o_sec, tod % 60);
    check_eq("m_min", o_min, (tod / 60) % 60);
    check_eq("m_hour", o_hour, hd);
    check_eq("m_pm", o_pm, (i_h12 && h24 >= 12) ? 1 : 0);
    check_eq("m_mode", o_mode, md);
    check_eq("m_pos", o_pos, ps);
    check_eq("m_mask", o_blink_mask, (md == 1 && bph == 1) ? (1 << ps) : 0);
    check_eq("m_tick", o_sec_tick, mtick);
    check_eq("m_wrap", o_day_wrap, mwrap);
  endtask

  task automatic cycle(input bit mo, input bit po, input bit inc, input bit dec);
    i_mode_pulse = mo; i_pos_pulse = po; i_inc_pulse = inc; i_dec_pulse = dec;
    @(posedge clk);
    model_step(mo, po, inc, dec);
    #1;
    i_mode_pulse = 1'b0; i_pos_pulse = 1'b0; i_inc_pulse = 1'b0; i_dec_pulse = 1'b0;
    compare_model();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_sec", o_sec, 0);
    check_eq("rst_min", o_min, 0);
    check_eq("rst_hour", o_hour, i_h12 ? 12 : 0);
    check_eq("rst_pm", o_pm, 0);
    check_eq("rst_mode", o_mode, 0);
    check_eq("rst_pos", o_pos, 0);
    check_eq("rst_mask", o_blink_mask, 0);
    check_eq("rst_tick", o_sec_tick, 0);
    check_eq("rst_wrap", o_day_wrap, 0);
  endtask

  int map_h[5]   = '{0, 11, 12, 13, 23};
  int map_12[5]  = '{12, 11, 12, 1, 11};
  int map_pm[5]  = '{0, 0, 1, 1, 1};

  task automatic check_map(input int idx);
    i_h12 = 1'b0; #1;
    check_eq("map24_hour", o_hour, map_h[idx]);
    check_eq("map24_pm", o_pm, 0);
    i_h12 = 1'b1; #1;
    check_eq("map12_hour", o_hour, map_12[idx]);
    check_eq("map12_pm", o_pm, map_pm[idx]);
    i_h12 = 1'b0; #1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_mode_pulse = 1'b0; i_pos_pulse = 1'b0; i_inc_pulse = 1'b0; i_dec_pulse = 1'b0;
    i_h12 = 1'b0;
    model_reset();
    #12;
    check_reset_outputs();
    i_h12 = 1'b1; #1;
    check_reset_outputs();
    i_h12 = 1'b0;
    rst_n = 1'b1;

    // First ticks after reset release.
    for (int c = 1; c <= 12; c++) begin
      cycle(0, 0, 0, 0);
      check_eq("first_tick", o_sec_tick, (c % 4 == 0) ? 1 : 0);
      if (c % 4 == 0) check_eq("first_sec", o_sec, c / 4);
    end

    // Enter SETUP, blink phase pattern.
    cycle(1, 0, 0, 0);
    check_eq("setup_mode", o_mode, 1);
    check_eq("setup_mask0", o_blink_mask, 0);
    for (int j = 1; j <= 5; j++) begin
      cycle(0, 0, 0, 0);
      check_eq("blink_mask", o_blink_mask, (j >= 3) ? 3'b001 : 3'b000);
    end
    cycle(0, 1, 0, 0);
    check_eq("pos_mask", o_blink_mask, 0);
    check_eq("pos_min", o_pos, 1);

    // Hour to 5, then min dec wrap.
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("min_dec_wrap", o_min, 59);
    check_eq("hour_kept", o_hour, 5);

    // 12h mapping sweep over hour field.
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1);
    check_map(0);
    for (int k = 1; k <= 23; k++) begin
      cycle(0, 0, 1, 0);
      for (int q = 1; q < 5; q++) if (map_h[q] == k) check_map(q);
    end
    cycle(0, 0, 1, 0);
    check_eq("hour_inc_wrap", o_hour, 0);
    check_eq("edit_no_wrap", o_day_wrap, 0);
    cycle(0, 0, 0, 1);
    check_eq("hour_dec_wrap", o_hour, 23);

    // Seconds to 59, then conflicts.
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1);
    check_eq("sec_59", o_sec, 59);
    cycle(0, 0, 1, 1);
    check_eq("incdec_sec", o_sec, 59);
    cycle(1, 0, 1, 0);
    check_eq("modeinc_mode", o_mode, 0);
    check_eq("modeinc_sec", o_sec, 59);

    // Rollover after leaving SETUP; inc in CLOCK ignored.
    for (int j = 1; j <= 5; j++) begin
      cycle(0, 0, (j == 2), 0);
      check_eq("roll_mask", o_blink_mask, 0);
      check_eq("roll_tick", o_sec_tick, (j == 4) ? 1 : 0);
      check_eq("roll_wrap", o_day_wrap, (j == 4) ? 1 : 0);
      check_eq("roll_sec", o_sec, (j >= 4) ? 0 : 59);
      if (j == 4) begin
        check_eq("roll_min", o_min, 0);
        check_eq("roll_hour", o_hour, 0);
      end
    end

    // Randomized pulses with a mid-run reset.
    for (int it = 0; it < 3000; it++) begin
      if (it % 64 == 0) i_h12 = 1'($urandom_range(0, 1));
      if (it == 1500) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
